sprite_rom_arbiter: RTL

//  Shares one single-port synchronous sprite-mask ROM among N render requesters (pacman, ghosts, dots, overlays).
//  - Each requester asks for one row of one sprite (sprite_id, row).
//  - The arbiter grants requests round-robin and issues the ROM read.
//  - It returns the TILE-bit row mask, tagged back to the requester that asked.
//  - Sits between the sprite ROM (built from the image mask tables) and the per-object pixel generators.

---
 rtl/sprite_pkg.sv | 47 ++++
 rtl/rr_pick.sv | 31 +++
 rtl/sprite_rom_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared constants for the sprite-mask ROM: geometry, sprite ids, address packing.
package sprite_pkg;

    localparam int TILE_SIZE = 16;
    localparam int ROW_W     = 4;
    localparam int SID_W     = 5;
    localparam int ADDR_W    = SID_W + ROW_W;

    // Requester tags are carried at the width of the largest supported N_REQ (8).
    localparam int TAG_W     = 3;

    localparam logic [SID_W-1:0] SID_DOT       = 5'd0;
    localparam logic [SID_W-1:0] SID_BIG_DOT   = 5'd1;
    localparam logic [SID_W-1:0] SID_PACMAN_F1 = 5'd2;
    localparam logic [SID_W-1:0] SID_PACMAN_F2 = 5'd3;
    localparam logic [SID_W-1:0] SID_GHOST_F1  = 5'd4;
    localparam logic [SID_W-1:0] SID_GHOST_F2  = 5'd5;
    localparam logic [SID_W-1:0] SID_SCLERA_U  = 5'd6;
    localparam logic [SID_W-1:0] SID_SCLERA_D  = 5'd7;
    localparam logic [SID_W-1:0] SID_SCLERA_L  = 5'd8;
    localparam logic [SID_W-1:0] SID_SCLERA_R  = 5'd9;
    localparam logic [SID_W-1:0] SID_EYE_U     = 5'd10;
    localparam logic [SID_W-1:0] SID_EYE_D     = 5'd11;
    localparam logic [SID_W-1:0] SID_EYE_L     = 5'd12;
    localparam logic [SID_W-1:0] SID_EYE_R     = 5'd13;
    localparam logic [SID_W-1:0] SID_VOID_F1   = 5'd14;
    localparam logic [SID_W-1:0] SID_VOID_F2   = 5'd15;
    localparam logic [SID_W-1:0] SID_VOID_FACE = 5'd16;
    // Ids 17 and 18 are populated in the ROM image but have no symbolic name yet.
    localparam int NUM_SPRITES = 19;

    typedef struct packed {
        logic             valid;
        logic             ok;
        logic [TAG_W-1:0] tag;
    } stage_t;

    function automatic logic [ADDR_W-1:0] rom_addr_of(input logic [SID_W-1:0] sid,
                                                      input logic [ROW_W-1:0] row);
        return {sid, row};
    endfunction

    function automatic logic sid_valid(input logic [SID_W-1:0] sid);
        return int'(sid) < NUM_SPRITES;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: first asserted request at or after ptr, wrapping mod N.
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] index,
    output logic             any
);

    logic [PTR_W-1:0] sel;

    // Walk the requests starting at ptr; the first hit wins and later hits are ignored.
    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        sel   = '0;
        for (int k = 0; k < N; k++) begin
            sel = PTR_W'((int'(ptr) + k) % N);
            if (!any && req[sel]) begin
                any        = 1'b1;
                index      = sel;
                grant[sel] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite-mask ROM among N_REQ requesters.
// Fixed 3-cycle ack-to-response pipeline; responses carry the requester tag back.
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*SID_W-1:0] req_sid,
    input  logic [N_REQ*ROW_W-1:0] req_row,
    output logic [N_REQ-1:0]       ack,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [TILE_SIZE-1:0]   rsp_data,
    output logic                   rom_en,
    output logic [ADDR_W-1:0]      rom_addr,
    input  logic [TILE_SIZE-1:0]   rom_data
);

    localparam int PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_nxt;
    logic [N_REQ-1:0] grant;
    logic [PTR_W-1:0] win;
    logic             any;
    logic [SID_W-1:0] win_sid;
    logic [ROW_W-1:0] win_row;
    logic             sid_ok;
    stage_t           s1;
    stage_t           s2;

    rr_pick #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .grant (grant),
        .index (win),
        .any   (any)
    );

    // Grant is combinational in the request cycle, suppressed while reset is held.
    always_comb begin
        ack = rst ? '0 : grant;
    end

    // Select the winner's operands and work out the pointer that follows it.
    always_comb begin
        win_sid = '0;
        win_row = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                win_sid = req_sid[i*SID_W +: SID_W];
                win_row = req_row[i*ROW_W +: ROW_W];
            end
        end
        sid_ok  = sid_valid(win_sid);
        ptr_nxt = (win == PTR_W'(N_REQ - 1)) ? '0 : win + PTR_W'(1);
    end

    // Pointer moves past the winner; idle cycles leave it where it is.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (any) begin
            ptr <= ptr_nxt;
        end
    end

    // S1: issue the ROM read. Out-of-range sprites travel down the pipe without touching the ROM.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= '0;
            rom_en   <= 1'b0;
            rom_addr <= '0;
        end else begin
            s1     <= '{valid: any, ok: sid_ok, tag: TAG_W'(win)};
            rom_en <= any && sid_ok;
            if (any) begin
                rom_addr <= rom_addr_of(win_sid, win_row);
            end
        end
    end

    // S2: ROM data is in flight; carry the tag alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2 <= '0;
        end else begin
            s2 <= s1;
        end
    end

    // S3: capture the row mask (zero for invalid sprites) and pulse the owner's valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                rsp_valid[i] <= s2.valid && (s2.tag == TAG_W'(i));
            end
            if (s2.valid) begin
                rsp_data <= s2.ok ? rom_data : '0;
            end
        end
    end

endmodule
